// File: rtl/polar_enc_frame_ctrl_pkg.sv
// polar_enc_pkg: shared constants, FSM state type and bit helpers for the N=32 polar encoder
//   N / LOG2N       codeword length and index width
//   FROZEN_INIT_DEF default frozen mask (bit i = 1 -> u[i] frozen to 0)
//   state_t         controller states LOAD / XFORM / EMIT
//   bitrev5         5-bit index reversal
//   ffs32           index of the lowest set bit (0 when none set)
package polar_enc_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;

    localparam logic [N-1:0] FROZEN_INIT_DEF = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        LOAD,
        XFORM,
        EMIT
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    // Scans downward so the lowest set bit is the last one written.
    function automatic logic [LOG2N-1:0] ffs32(input logic [N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) r = i[LOG2N-1:0];
        return r;
    endfunction

endpackage

// File: rtl/polar_enc_frame_ctrl_if.sv
// polar_enc_frame_ctrl_if: one-bit valid/ready stream with end-of-frame marker
//   valid  source has a bit
//   ready  sink accepts the bit
//   data   the bit
//   last   final bit of the frame
//   master drives valid/data/last, slave drives ready
interface polar_enc_frame_ctrl_if;

    logic valid;
    logic ready;
    logic data;
    logic last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);

endinterface

// File: rtl/polar_enc_frame_ctrl_xform.sv
// polar_enc_frame_ctrl_xform: registered 32-point polar transform, x_i = XOR of u_j over all j subset of i
//   clk     clock
//   rst_n   asynchronous active-low reset, clears dout_o
//   din_i   u vector
//   dout_o  x vector, one cycle after din_i
module polar_enc_frame_ctrl_xform
    import polar_enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] dout_o
);

    logic [N-1:0] x_d;

    always_comb begin
        x_d = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if ((j & i) == j) x_d[i] = x_d[i] ^ din_i[j];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dout_o <= '0;
        else        dout_o <= x_d;

endmodule

// File: rtl/polar_enc_frame_ctrl.sv
// polar_enc_frame_ctrl: frame sequencer packing serial info bits into u, running the transform and streaming x out
//   clk           clock
//   rst_n         asynchronous active-low reset
//   cfg_we_i      frozen-mask write strobe
//   cfg_frozen_i  new frozen mask (bit i = 1 -> u[i] frozen)
//   cfg_err_o     one-cycle pulse after an all-ones mask write was rejected
//   s_if          info-bit input stream (slave)
//   m_if          codeword-bit output stream (master), m_if.last on the 32nd bit
//   len_err_o     one-cycle pulse after the closing info bit: [0] s_last early, [1] K-th bit without s_last
//   busy_o        frame in progress
// Build option: POLAR_ENC_BITREV_EN emits the codeword in bit-reversed index order.
module polar_enc_frame_ctrl
    import polar_enc_pkg::*;
#(
    parameter logic [N-1:0] FROZEN_INIT = FROZEN_INIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we_i,
    input  logic [N-1:0]           cfg_frozen_i,
    output logic                   cfg_err_o,
    polar_enc_frame_ctrl_if.slave  s_if,
    polar_enc_frame_ctrl_if.master m_if,
    output logic [1:0]             len_err_o,
    output logic                   busy_o
);

    state_t           state_q;
    logic [N-1:0]     u_q, rem_q, mask_q, pmask_q, x;
    logic [LOG2N-1:0] idx_q, pos, emit_idx;
    logic             pend_q, s_ready_q, m_valid_q, m_last_q;

    logic             s_acc, m_acc, fill_done, cfg_ok, cfg_now, pend_d;
    logic [N-1:0]     rem_left, pmask_d, next_mask;

    polar_enc_frame_ctrl_xform u_xform (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (u_q),
        .dout_o (x)
    );

    always_comb begin
        s_acc     = s_if.valid & s_ready_q;
        m_acc     = m_valid_q & m_if.ready;
        pos       = ffs32(rem_q);
        rem_left  = rem_q & ~(32'd1 << pos);
        fill_done = rem_left == '0;
        cfg_ok    = cfg_we_i & ~(&cfg_frozen_i);
        // A write lands immediately only while nothing of the current frame has been taken;
        // a bit accepted in the same cycle claims the old mask.
        cfg_now   = cfg_ok & (state_q == LOAD) & (rem_q == ~mask_q) & ~s_acc;
        pend_d    = (cfg_ok & ~cfg_now) | pend_q;
        pmask_d   = cfg_ok ? cfg_frozen_i : pmask_q;
        next_mask = pend_d ? pmask_d : mask_q;
`ifdef POLAR_ENC_BITREV_EN
        emit_idx  = bitrev5(idx_q);
`else
        emit_idx  = idx_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            u_q       <= '0;
            rem_q     <= ~FROZEN_INIT;
            mask_q    <= FROZEN_INIT;
            pmask_q   <= FROZEN_INIT;
            pend_q    <= 1'b0;
            idx_q     <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            cfg_err_o <= 1'b0;
            len_err_o <= 2'b00;
        end else begin
            cfg_err_o <= cfg_we_i & (&cfg_frozen_i);
            len_err_o <= 2'b00;
            pend_q    <= pend_d;
            pmask_q   <= pmask_d;
            if (cfg_now) begin
                mask_q <= cfg_frozen_i;
                rem_q  <= ~cfg_frozen_i;
            end
            case (state_q)
                LOAD: if (s_acc) begin
                    u_q[pos] <= s_if.data;
                    rem_q    <= rem_left;
                    if (fill_done | s_if.last) begin
                        state_q   <= XFORM;
                        s_ready_q <= 1'b0;
                        len_err_o <= {fill_done & ~s_if.last, s_if.last & ~fill_done};
                    end
                end
                // The core samples u during this cycle, so x is valid from the first EMIT cycle.
                XFORM: begin
                    state_q   <= EMIT;
                    idx_q     <= '0;
                    m_valid_q <= 1'b1;
                    m_last_q  <= 1'b0;
                end
                EMIT: if (m_acc) begin
                    idx_q    <= idx_q + 5'd1;
                    m_last_q <= idx_q == 5'd30;
                    if (m_last_q) begin
                        state_q   <= LOAD;
                        idx_q     <= '0;
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        s_ready_q <= 1'b1;
                        u_q       <= '0;
                        mask_q    <= next_mask;
                        rem_q     <= ~next_mask;
                        pend_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= LOAD;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.ready = s_ready_q;
    assign m_if.valid = m_valid_q;
    assign m_if.last  = m_last_q;
    assign m_if.data  = m_valid_q & x[emit_idx];
    assign busy_o     = (state_q != LOAD) || (rem_q != ~mask_q);

endmodule

// File: tb/tb_polar_enc_frame_ctrl.sv
// tb_polar_enc_frame_ctrl: directed frames checked against a butterfly-transform model of the encoder
module tb_polar_enc_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_frozen = '0;
    logic        cfg_err, busy;
    logic [1:0]  len_err;

    polar_enc_frame_ctrl_if s_if ();
    polar_enc_frame_ctrl_if m_if ();

    polar_enc_frame_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_frozen_i (cfg_frozen),
        .cfg_err_o    (cfg_err),
        .s_if         (s_if),
        .m_if         (m_if),
        .len_err_o    (len_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          exp_q[$];
    int          cnt = 0;
    logic [31:0] got_cw = '0;
    logic [31:0] mdl_mask = 32'hFFFF_0000;
    logic [31:0] lit;
    bit          mr_toggle = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Fill info positions in ascending order, then a subset-sum butterfly gives x.
    function automatic logic [31:0] mdl_cw(input logic [31:0] mask, input logic [31:0] bits, input int n);
        logic [31:0] v;
        int k;
        v = '0;
        k = 0;
        for (int i = 0; i < 32; i++)
            if (!mask[i] && k < n) begin
                v[i] = bits[k];
                k++;
            end
        for (int s = 0; s < 5; s++)
            for (int i = 0; i < 32; i++)
                if ((i & (1 << s)) != 0) v[i] = v[i] ^ v[i ^ (1 << s)];
        return v;
    endfunction

    function automatic int ord(input int idx);
        logic [4:0] a;
        a = idx[4:0];
`ifdef POLAR_ENC_BITREV_EN
        return int'({a[0], a[1], a[2], a[3], a[4]});
`else
        return int'(a);
`endif
    endfunction

    task automatic push_exp(input logic [31:0] x);
        for (int i = 0; i < 32; i++) exp_q.push_back(x[ord(i)]);
    endtask

    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = mr_toggle ? ~m_if.ready : 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            cnt = 0;
            chk("m_valid_in_reset", m_if.valid, 0);
        end else if (m_if.valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_m_valid got 1 expected 0 at %0t", $time);
            end else begin
                chk("m_data", m_if.data, exp_q[0]);
                chk("m_last", m_if.last, cnt == 31);
                if (m_if.ready) begin
                    got_cw[cnt] = m_if.data;
                    void'(exp_q.pop_front());
                    cnt = (cnt + 1) % 32;
                end
            end
        end
    end

    task automatic cfg(input logic [31:0] val);
        cfg_we = 1'b1;
        cfg_frozen = val;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk("cfg_err", cfg_err, &val);
    endtask

    task automatic send(input logic [31:0] bits, input int n, input bit last, input logic [1:0] exp_le);
        push_exp(mdl_cw(mdl_mask, bits, n));
        for (int k = 0; k < n; k++) begin
            int w;
            s_if.valid = 1'b1;
            s_if.data  = bits[k];
            s_if.last  = last && (k == n - 1);
            w = 0;
            @(negedge clk);
            while (!s_if.ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk("s_ready_wait", s_if.ready, 1);
            @(posedge clk);
            #1;
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        chk("len_err", len_err, exp_le);
        chk("m_valid_t1", m_if.valid, 0);
        chk("s_ready_xform", s_if.ready, 0);
        chk("busy_xform", busy, 1);
        @(posedge clk);
        #1;
        chk("m_valid_t2", m_if.valid, 1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_left", exp_q.size(), 0);
        chk("s_ready_back", s_if.ready, 1);
        chk("m_valid_idle", m_if.valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.valid = 1'b0;
        s_if.data  = 1'b0;
        s_if.last  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_s_ready", s_if.ready, 1);
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_m_data", m_if.data, 0);
        chk("rst_m_last", m_if.last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_len_err", len_err, 0);

        cfg(32'h7FFF_FFFF);
        mdl_mask = 32'h7FFF_FFFF;
        chk("busy_after_cfg", busy, 0);
        send(32'h1, 1, 1, 2'b00);
        drain();
        chk("cw_single_u31", got_cw, 32'h8000_0000);

        cfg(32'hFFFF_FFFE);
        mdl_mask = 32'hFFFF_FFFE;
        send(32'h1, 1, 1, 2'b00);
        drain();
        chk("cw_single_u0", got_cw, 32'hFFFF_FFFF);

        cfg(32'hFFFF_0000);
        mdl_mask = 32'hFFFF_0000;
        mr_toggle = 1'b1;
        send(32'h5555, 16, 1, 2'b00);
        drain();
        mr_toggle = 1'b0;
        chk("cw_alt16", got_cw, 32'h0003_0003);

        send(32'hF, 4, 1, 2'b01);
        drain();
`ifdef POLAR_ENC_BITREV_EN
        lit = 32'h0000_00FF;
`else
        lit = 32'h1111_1111;
`endif
        chk("cw_early_last", got_cw, lit);
        send(32'hFFFF, 16, 1, 2'b00);
        drain();

        send(32'hA5C3, 16, 1, 2'b00);
        cfg(32'hFFFF_FF00);
        chk("busy_pending", busy, 1);
        drain();
        mdl_mask = 32'hFFFF_FF00;
        send(32'hB6, 8, 1, 2'b00);
        drain();
        cfg(32'hFFFF_FFFF);
        chk("busy_rejected", busy, 0);
        send(32'h3C, 8, 0, 2'b10);
        drain();

        send(32'h5A, 8, 1, 2'b00);
        begin
            int w;
            w = 0;
            while (cnt != 10 && w < 100) begin
                @(posedge clk);
                w++;
            end
        end
        chk("reached_idx10", cnt, 10);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_if.valid, 0);
        chk("mid_rst_m_last", m_if.last, 0);
        chk("mid_rst_s_ready", s_if.ready, 1);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_mask = 32'hFFFF_0000;
        chk("post_rst_s_ready", s_if.ready, 1);
        send(32'h1234, 16, 1, 2'b00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
